mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multi-cycle control FSM for the 4-bit-opcode datapath. Replaces single-cycle decode with FETCH/DECODE/EXEC/MEM/WB sequencing.
- Adds a memory ready handshake with timeout, illegal-opcode trapping, and an opcode width parameter.
- Sits between the instruction register / ALU zero flag and the datapath muxes, register file and shared memory port.

Parameters:
OP_W, 4, opcode width (>=4); any nonzero bit above bit 3 makes the opcode illegal
MEM_TIMEOUT, 15, maximum consecutive wait cycles with mem_ready low before trapping (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; leaves IDLE when high
op_code  in  OP_W  current IR opcode; valid from DECODE onward
zero  in  1  ALU zero flag, sampled in DECODE for boz
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
i_or_d  out  1  0 = PC address, 1 = ALU address
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
alu_src  out  1  1 = immediate operand
alu_op  out  2  00 = add, 01 = subtract (comp), 10 = function from opcode
reg_write  out  1  register file write
reg_dst  out  1  1 = rd field, 0 = rt field
mem_to_reg  out  1  writeback from memory data
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  sticky trap flag, illegal opcode
timeout  out  1  sticky trap flag, memory timeout
state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
- Opcode classes, decoded on bits [3:0] with upper bits zero:
  - load 0000, store 0010, stri 0100, boz 0110, bran 1000, comp 1010
  - bit0=1: R-type ALU op
  - 1100 and 1110: illegal
- Class is latched in a register at the DECODE edge. EXEC/MEM/WB use the latched class, not the live op_code.
- Reset (async, rst_n low): state=IDLE, class reg cleared, wait counter=0, illegal=0, timeout=0.
  - All control outputs are 0 in IDLE.
  - Reset mid-instruction abandons the instruction without issuing any strobe.
- All outputs except state/illegal/timeout are decoded combinationally from state, latched class, zero and mem_ready. Every unlisted output is 0.
- IDLE: stay while run=0; run=1 -> FETCH next edge.
- FETCH:
  - mem_req=1, i_or_d=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, -> DECODE.
  - Else stay and increment the wait counter.
- DECODE:
  - Illegal opcode -> TRAP, set illegal.
  - boz: if zero, pc_write=1 with pc_src=01. instr_done=1, -> FETCH.
  - bran: pc_write=1, pc_src=10, instr_done=1, -> FETCH.
  - All other classes -> EXEC.
- EXEC:
  - load/store/stri: alu_src=1, alu_op=00.
  - comp: alu_op=01.
  - R-type: alu_op=10.
  - load/store -> MEM; others -> WB.
- MEM:
  - mem_req=1, i_or_d=1, mem_we=store.
  - On mem_ready: store sets instr_done=1 and goes -> FETCH; load goes -> WB.
  - Else stay and increment the wait counter.
- WB:
  - reg_write=1.
  - reg_dst=1 for comp/R-type, 0 for load/stri.
  - mem_to_reg=1 for load.
  - instr_done=1, -> FETCH.
- Wait counter:
  - Cleared on every state change.
  - While in FETCH/MEM with mem_ready=0: when the count equals MEM_TIMEOUT-1, the next edge goes to TRAP and sets timeout. Exactly MEM_TIMEOUT wait cycles are tolerated.
  - mem_ready arriving on the final permitted cycle wins; no trap.
  - Width is clog2(MEM_TIMEOUT+1); no wrap is possible.
- TRAP: all strobes 0; held until rst_n. run is ignored.
- Zero-wait latency: branch 2 cycles, R-type/comp/stri 4, store 4, load 5. Each memory wait cycle adds one.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset then run=1, op 0001, mem_ready=1 always -> states 1,2,3,5; reg_write=1, reg_dst=1, alu_op=10 in WB; instr_done only in WB.
- Load 0000 with mem_ready low for 3 cycles in MEM -> 8 cycles total; mem_req=1, i_or_d=1, mem_we=0 throughout MEM; mem_to_reg=1, reg_dst=0 in WB.
- boz 0110 with zero=1, then again with zero=0 -> pc_write=1/pc_src=01 in DECODE for the first, pc_write=0 for the second; both return to FETCH after 2 cycles.
- op 1100, then OP_W=6 with op 010001 -> state=6, illegal=1 and held; no reg_write or mem_req until rst_n low.
- MEM_TIMEOUT=4, mem_ready low in FETCH -> TRAP after exactly 4 wait cycles with timeout=1. Repeat with mem_ready high on the 4th cycle -> DECODE, no trap.
- Assert rst_n low mid-MEM of a store -> state=0 immediately (async); mem_we=0 with no clock edge.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl_unit and the datapath/memory side.
// master = datapath/memory side, slave = the control unit.
interface mc_ctrl_if #(
  parameter int OP_W = 4
);
  // mem_req is a level request held for the whole FETCH/MEM phase; the
  // transfer completes on any cycle where mem_req and mem_ready are both high.
  logic            run;
  logic [OP_W-1:0] op_code;
  logic            zero;
  logic            mem_ready;

  logic            mem_req;
  logic            mem_we;
  logic            i_or_d;
  logic            ir_write;
  logic            pc_write;
  logic [1:0]      pc_src;
  logic            alu_src;
  logic [1:0]      alu_op;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            instr_done;

  modport master (
    output run, op_code, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, reg_dst, mem_to_reg, instr_done
  );

  modport slave (
    input  run, op_code, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, reg_dst, mem_to_reg, instr_done
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// ready handshake, wait timeout and illegal-opcode trap.
module mc_ctrl_unit #(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.slave    bus,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD  = 3'd0,
    C_STORE = 3'd1,
    C_STRI  = 3'd2,
    C_BOZ   = 3'd3,
    C_BRAN  = 3'd4,
    C_COMP  = 3'd5,
    C_RTYPE = 3'd6,
    C_ILL   = 3'd7
  } class_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t          st;
  class_t          cls_q;
  class_t          dec_cls;
  logic [CW-1:0]   wait_cnt;
  logic [OP_W-1:0] op;

  assign op    = bus.op_code;
  assign state = st;

  // Any set bit above the 4-bit opcode field makes the opcode illegal.
  always_comb begin
    dec_cls = C_ILL;
    if ((op >> 4) == '0) begin
      if (op[0]) begin
        dec_cls = C_RTYPE;
      end else begin
        case (op[3:1])
          3'b000:  dec_cls = C_LOAD;
          3'b001:  dec_cls = C_STORE;
          3'b010:  dec_cls = C_STRI;
          3'b011:  dec_cls = C_BOZ;
          3'b100:  dec_cls = C_BRAN;
          3'b101:  dec_cls = C_COMP;
          default: dec_cls = C_ILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      cls_q    <= C_LOAD;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (bus.run) st <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            st       <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            st       <= S_TRAP;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          case (dec_cls)
            C_ILL: begin
              st      <= S_TRAP;
              illegal <= 1'b1;
            end
            C_BOZ, C_BRAN: st <= S_FETCH;
            default:       st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (cls_q == C_LOAD || cls_q == C_STORE) st <= S_MEM;
          else                                     st <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            st       <= (cls_q == C_STORE) ? S_FETCH : S_WB;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            st       <= S_TRAP;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_IDLE;
      endcase
    end
  end

  // DECODE acts on the live opcode because the class register loads on that edge.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src    = 1'b0;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.instr_done = 1'b0;
    case (st)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_BOZ) begin
          bus.instr_done = 1'b1;
          if (bus.zero) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b01;
          end
        end else if (dec_cls == C_BRAN) begin
          bus.instr_done = 1'b1;
          bus.pc_write   = 1'b1;
          bus.pc_src     = 2'b10;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE, C_STRI: bus.alu_src = 1'b1;
          C_COMP:                  bus.alu_op  = 2'b01;
          C_RTYPE:                 bus.alu_op  = 2'b10;
          default:                 bus.alu_op  = 2'b00;
        endcase
      end
      S_MEM: begin
        bus.mem_req    = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.mem_we     = (cls_q == C_STORE);
        bus.instr_done = bus.mem_ready && (cls_q == C_STORE);
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (cls_q == C_COMP) || (cls_q == C_RTYPE);
        bus.mem_to_reg = (cls_q == C_LOAD);
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: vector table on a default instance plus
// hand sequences on an OP_W=6 / MEM_TIMEOUT=4 instance.
module tb_mc_ctrl_unit;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if #(.OP_W(4)) bus0 ();
  mc_ctrl_if #(.OP_W(6)) bus1 ();

  logic [2:0] st0, st1;
  logic       ill0, ill1, tmo0, tmo1;

  mc_ctrl_unit #(.OP_W(4), .MEM_TIMEOUT(15)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .state(st0), .illegal(ill0), .timeout(tmo0)
  );

  mc_ctrl_unit #(.OP_W(6), .MEM_TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .state(st1), .illegal(ill1), .timeout(tmo1)
  );

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src, alu_op,
  //  reg_write, reg_dst, mem_to_reg, instr_done}
  logic [13:0] ctl0, ctl1;
  assign ctl0 = {bus0.mem_req, bus0.mem_we, bus0.i_or_d, bus0.ir_write, bus0.pc_write,
                 bus0.pc_src, bus0.alu_src, bus0.alu_op, bus0.reg_write, bus0.reg_dst,
                 bus0.mem_to_reg, bus0.instr_done};
  assign ctl1 = {bus1.mem_req, bus1.mem_we, bus1.i_or_d, bus1.ir_write, bus1.pc_write,
                 bus1.pc_src, bus1.alu_src, bus1.alu_op, bus1.reg_write, bus1.reg_dst,
                 bus1.mem_to_reg, bus1.instr_done};

  localparam logic [13:0] MREQ    = 14'h2000;
  localparam logic [13:0] MWE     = 14'h1000;
  localparam logic [13:0] IOD     = 14'h0800;
  localparam logic [13:0] IRW     = 14'h0400;
  localparam logic [13:0] PCW     = 14'h0200;
  localparam logic [13:0] PCS_J   = 14'h0100;
  localparam logic [13:0] PCS_BR  = 14'h0080;
  localparam logic [13:0] ASRC    = 14'h0040;
  localparam logic [13:0] AOP_FN  = 14'h0020;
  localparam logic [13:0] AOP_SUB = 14'h0010;
  localparam logic [13:0] RW      = 14'h0008;
  localparam logic [13:0] RDST    = 14'h0004;
  localparam logic [13:0] M2R     = 14'h0002;
  localparam logic [13:0] DONE    = 14'h0001;
  localparam logic [13:0] F_OK    = MREQ | IRW | PCW;
  localparam logic [3:0]  XOP     = 4'b1110;

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic        zero;
    logic        mr;
    logic [2:0]  st;
    logic [13:0] ctl;
    logic        ill;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic run, logic [3:0] op, logic zero, logic mr,
                              logic [2:0] st, logic [13:0] ctl, logic ill);
    vec_t v;
    v.run = run; v.op = op; v.zero = zero; v.mr = mr;
    v.st = st; v.ctl = ctl; v.ill = ill; v.tmo = 1'b0;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus0.run = 0; bus0.op_code = '0; bus0.zero = 0; bus0.mem_ready = 0;
    bus1.run = 0; bus1.op_code = '0; bus1.zero = 0; bus1.mem_ready = 0;

    // idle and R-type 0001
    vecs.push_back(mk(0, 4'b0001, 0, 1, 0, 14'h0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 1, 0, 14'h0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 0, 14'h0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 3, AOP_FN, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 5, RW | RDST | DONE, 0));
    // load with 3 wait cycles in MEM
    vecs.push_back(mk(1, 4'b0000, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 3, ASRC, 0));
    vecs.push_back(mk(1, XOP,     0, 0, 4, MREQ | IOD, 0));
    vecs.push_back(mk(1, XOP,     0, 0, 4, MREQ | IOD, 0));
    vecs.push_back(mk(1, XOP,     0, 0, 4, MREQ | IOD, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 4, MREQ | IOD, 0));
    vecs.push_back(mk(1, XOP,     0, 0, 5, RW | M2R | DONE, 0));
    // boz taken, then not taken
    vecs.push_back(mk(1, 4'b0110, 1, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0110, 1, 0, 2, PCW | PCS_BR | DONE, 0));
    vecs.push_back(mk(1, 4'b0110, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0110, 0, 1, 2, DONE, 0));
    // bran
    vecs.push_back(mk(1, 4'b1000, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 1, 2, PCW | PCS_J | DONE, 0));
    // store, live opcode changed after DECODE
    vecs.push_back(mk(1, 4'b0010, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 3, ASRC, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 4, MREQ | MWE | IOD | DONE, 0));
    // comp
    vecs.push_back(mk(1, 4'b1010, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b1010, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 3, AOP_SUB, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 5, RW | RDST | DONE, 0));
    // stri
    vecs.push_back(mk(1, 4'b0100, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 3, ASRC, 0));
    vecs.push_back(mk(1, XOP,     0, 1, 5, RW | DONE, 0));
    // one FETCH wait, then illegal 1100 traps and holds
    vecs.push_back(mk(1, 4'b1100, 0, 0, 1, MREQ, 0));
    vecs.push_back(mk(1, 4'b1100, 0, 1, 1, F_OK, 0));
    vecs.push_back(mk(1, 4'b1100, 0, 1, 2, 14'h0, 0));
    vecs.push_back(mk(1, 4'b1100, 0, 1, 6, 14'h0, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 1, 6, 14'h0, 1));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 6, 14'h0, 1));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst u0 state", 32'(st0), 32'd0);
    chk("rst u0 ctl", 32'(ctl0), 32'd0);
    chk("rst u0 flags", 32'({ill0, tmo0}), 32'd0);
    chk("rst u1 state", 32'(st1), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus0.run = vecs[i].run;
      bus0.op_code = vecs[i].op;
      bus0.zero = vecs[i].zero;
      bus0.mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d state", i), 32'(st0), 32'(vecs[i].st));
      chk($sformatf("vec%0d ctl", i), 32'(ctl0), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d flags", i), 32'({ill0, tmo0}), 32'({vecs[i].ill, vecs[i].tmo}));
      step();
    end

    // async reset in the middle of a store's MEM phase
    rst_n = 1'b0;
    #1;
    chk("trap rst state", 32'(st0), 32'd0);
    chk("trap rst illegal", 32'(ill0), 32'd0);
    rst_n = 1'b1;
    step();
    bus0.run = 1; bus0.op_code = 4'b0010; bus0.zero = 0; bus0.mem_ready = 1;
    step();
    step();
    step();
    bus0.mem_ready = 0;
    step();
    chk("store mem state", 32'(st0), 32'd4);
    chk("store mem we", 32'(bus0.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst state", 32'(st0), 32'd0);
    chk("async rst we", 32'(bus0.mem_we), 32'd0);
    chk("async rst ctl", 32'(ctl0), 32'd0);
    bus0.run = 0;
    step();
    rst_n = 1'b1;
    step();

    // OP_W=6: 010001 is illegal despite bit0=1
    bus1.run = 1; bus1.op_code = 6'b010001; bus1.mem_ready = 1;
    step();
    chk("op6 fetch", 32'(st1), 32'd1);
    step();
    chk("op6 decode", 32'(st1), 32'd2);
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("op6 trap state %0d", k), 32'(st1), 32'd6);
      chk($sformatf("op6 illegal %0d", k), 32'(ill1), 32'd1);
      chk($sformatf("op6 strobes %0d", k), 32'({bus1.mem_req, bus1.reg_write}), 32'd0);
      step();
    end

    // MEM_TIMEOUT=4: four wait cycles in FETCH then trap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus1.op_code = 6'b000001; bus1.mem_ready = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to wait state %0d", k), 32'(st1), 32'd1);
      chk($sformatf("to wait req %0d", k), 32'(bus1.mem_req), 32'd1);
      step();
    end
    chk("to trap state", 32'(st1), 32'd6);
    chk("to trap flags", 32'({ill1, tmo1}), 32'b01);

    // ready on the last permitted cycle wins
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("late wait state %0d", k), 32'(st1), 32'd1);
      step();
    end
    bus1.mem_ready = 1;
    #1;
    chk("late ir_write", 32'(bus1.ir_write), 32'd1);
    step();
    chk("late decode", 32'(st1), 32'd2);
    chk("late no timeout", 32'(tmo1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
